// File: rtl/econet_tx_sequencer.sv
// ---------------------------------------------------------------------------
// econet_tx_sequencer
//   Sequences one four-way transmit handshake (scout -> ack -> data -> ack)
//   on the shared serial line. Carrier sense and ack detection come from the
//   rx_deframer outputs; the transmit framer is driven with start pulses and
//   the outcome is reported to the host side as a done or fail pulse.
//
//   Optional feature macro: ECONET_BCAST_EN
//     defined   : a request with xfer_bcast=1 sends a single scout-format
//                 frame and completes on its tx_done (no ack wait, no retry).
//     undefined : xfer_bcast is ignored; every request is a four-way handshake.
//
// Ports
//   netclk      in   line bit clock
//   reset       in   asynchronous, active-high
//   xfer_req    in   level request, sampled only in IDLE
//   xfer_bcast  in   broadcast flag, sampled with xfer_req
//   line_idle   in   rx_deframer idle
//   rx_complete in   rx_deframer frame_complete (rising edge = frame event)
//   rx_valid    in   rx_deframer frame_valid (qualifies a frame event)
//   rx_abort    in   rx_deframer frame_abort (rising edge = abort event)
//   tx_done     in   framer pulse: closing flag of current frame sent
//   tx_start    out  one-cycle pulse: framer begins a frame
//   tx_sel      out  frame select with tx_start: 0 = scout, 1 = data
//   busy        out  high in every state except IDLE
//   xfer_done   out  one-cycle pulse: handshake completed
//   xfer_fail   out  one-cycle pulse: handshake failed
//   fail_code   out  01 scout unacked, 10 data unacked; held until next request
// ---------------------------------------------------------------------------
module econet_tx_sequencer #(
    parameter int LINE_IDLE_CYC = 16,
    parameter int ACK_TIMEOUT   = 2048,
    parameter int MAX_RETRY     = 3,
    parameter int CNT_W         = 12
) (
    input  logic       netclk,
    input  logic       reset,
    input  logic       xfer_req,
    input  logic       xfer_bcast,
    input  logic       line_idle,
    input  logic       rx_complete,
    input  logic       rx_valid,
    input  logic       rx_abort,
    input  logic       tx_done,
    output logic       tx_start,
    output logic       tx_sel,
    output logic       busy,
    output logic       xfer_done,
    output logic       xfer_fail,
    output logic [1:0] fail_code
);

    localparam int RTY_W = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);

    localparam logic [CNT_W-1:0] IDLE_MAX = CNT_W'(LINE_IDLE_CYC);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_LINE,
        S_SCOUT,
        S_ACK1,
        S_DATA,
        S_ACK2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] idle_cnt;
    logic [CNT_W-1:0] timer;
    logic [RTY_W-1:0] retry_cnt;
    logic             complete_d;
    logic             abort_d;

    logic             frame_ev;
    logic             abort_ev;
    logic             ack;
    logic             nak;
    logic             line_ready;
    logic             timeout;
    logic             retry_ok;
    logic             in_ack;
    logic             bcast_mode;

    logic             accept;
    logic             retry_inc;
    logic [1:0]       fail_set;

    // Event decode: an abort in the same cycle as a valid frame spoils the ack.
    assign frame_ev   = rx_complete & ~complete_d;
    assign abort_ev   = rx_abort & ~abort_d;
    assign ack        = frame_ev & rx_valid & ~abort_ev;
    assign nak        = (frame_ev & ~rx_valid) | abort_ev;
    assign line_ready = (idle_cnt == IDLE_MAX);
    assign timeout    = (timer == TMO_LAST);
    assign retry_ok   = (retry_cnt < RTY_MAX);
    assign in_ack     = (state == S_ACK1) || (state == S_ACK2);

`ifdef ECONET_BCAST_EN
    logic bcast_q;

    always_ff @(posedge netclk or posedge reset) begin
        if (reset) begin
            bcast_q <= 1'b0;
        end else if (accept) begin
            bcast_q <= xfer_bcast;
        end
    end

    assign bcast_mode = bcast_q;
`else
    logic unused_bcast;

    assign unused_bcast = xfer_bcast;
    assign bcast_mode   = 1'b0;
`endif

    // State register
    always_ff @(posedge netclk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. In the ack states an ack is tested first, so an
    // event arriving in the timeout cycle takes precedence over the timeout.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (xfer_req)   state_nxt = S_WAIT_LINE;
            S_WAIT_LINE: if (line_ready) state_nxt = S_SCOUT;
            S_SCOUT:     if (tx_done)    state_nxt = bcast_mode ? S_IDLE : S_ACK1;
            S_ACK1: begin
                if (ack) begin
                    state_nxt = S_DATA;
                end else if (nak || timeout) begin
                    state_nxt = retry_ok ? S_WAIT_LINE : S_IDLE;
                end
            end
            S_DATA:      if (tx_done)    state_nxt = S_ACK2;
            S_ACK2:      if (ack || nak || timeout) state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    // Output logic (Mealy: pulses coincide with the transition cycle)
    always_comb begin
        tx_start  = 1'b0;
        tx_sel    = 1'b0;
        busy      = (state != S_IDLE);
        xfer_done = 1'b0;
        xfer_fail = 1'b0;
        fail_set  = 2'b00;
        retry_inc = 1'b0;
        accept    = 1'b0;
        case (state)
            S_IDLE: accept = xfer_req;
            S_WAIT_LINE: begin
                if (line_ready) begin
                    tx_start = 1'b1;
                    tx_sel   = 1'b0;
                end
            end
            S_SCOUT: begin
                if (tx_done && bcast_mode) begin
                    xfer_done = 1'b1;
                end
            end
            S_ACK1: begin
                if (ack) begin
                    tx_start = 1'b1;
                    tx_sel   = 1'b1;
                end else if (nak || timeout) begin
                    if (retry_ok) begin
                        retry_inc = 1'b1;
                    end else begin
                        xfer_fail = 1'b1;
                        fail_set  = 2'b01;
                    end
                end
            end
            S_ACK2: begin
                if (ack) begin
                    xfer_done = 1'b1;
                end else if (nak || timeout) begin
                    xfer_fail = 1'b1;
                    fail_set  = 2'b10;
                end
            end
            default: ;
        endcase
    end

    // Counters, edge-detect history and held status
    always_ff @(posedge netclk or posedge reset) begin
        if (reset) begin
            idle_cnt   <= '0;
            timer      <= '0;
            retry_cnt  <= '0;
            complete_d <= 1'b0;
            abort_d    <= 1'b0;
            fail_code  <= 2'b00;
        end else begin
            complete_d <= rx_complete;
            abort_d    <= rx_abort;

            if (!line_idle) begin
                idle_cnt <= '0;
            end else if (idle_cnt != IDLE_MAX) begin
                idle_cnt <= idle_cnt + CNT_W'(1);
            end

            // Timer counts only while staying in an ack state; leaving on
            // timeout at TMO_LAST means it never wraps.
            if (in_ack && (state_nxt == state)) begin
                timer <= timer + CNT_W'(1);
            end else begin
                timer <= '0;
            end

            if (accept) begin
                retry_cnt <= '0;
            end else if (retry_inc) begin
                retry_cnt <= retry_cnt + RTY_W'(1);
            end

            if (accept) begin
                fail_code <= 2'b00;
            end else if (xfer_fail) begin
                fail_code <= fail_set;
            end
        end
    end

endmodule

// File: tb/tb_econet_tx_sequencer.sv
module tb_econet_tx_sequencer;

    logic       netclk      = 1'b0;
    logic       reset       = 1'b1;
    logic       xfer_req    = 1'b0;
    logic       xfer_bcast  = 1'b0;
    logic       line_idle   = 1'b0;
    logic       rx_complete = 1'b0;
    logic       rx_valid    = 1'b0;
    logic       rx_abort    = 1'b0;
    logic       tx_done     = 1'b0;
    logic       tx_start;
    logic       tx_sel;
    logic       busy;
    logic       xfer_done;
    logic       xfer_fail;
    logic [1:0] fail_code;

    int   cyc       = 0;
    int   n_start   = 0;
    int   n_done    = 0;
    int   n_fail    = 0;
    int   start_cyc = 0;
    int   done_cyc  = 0;
    int   fail_cyc  = 0;
    logic last_sel  = 1'b0;

    int   errors = 0;
    int   checks = 0;

    econet_tx_sequencer dut (
        .netclk     (netclk),
        .reset      (reset),
        .xfer_req   (xfer_req),
        .xfer_bcast (xfer_bcast),
        .line_idle  (line_idle),
        .rx_complete(rx_complete),
        .rx_valid   (rx_valid),
        .rx_abort   (rx_abort),
        .tx_done    (tx_done),
        .tx_start   (tx_start),
        .tx_sel     (tx_sel),
        .busy       (busy),
        .xfer_done  (xfer_done),
        .xfer_fail  (xfer_fail),
        .fail_code  (fail_code)
    );

    always #5 netclk = ~netclk;

    always @(posedge netclk) cyc <= cyc + 1;

    // Pulse recorder, sampled mid-cycle
    always @(negedge netclk) begin
        if (tx_start === 1'b1) begin
            n_start   <= n_start + 1;
            start_cyc <= cyc;
            last_sel  <= tx_sel;
        end
        if (xfer_done === 1'b1) begin
            n_done   <= n_done + 1;
            done_cyc <= cyc;
        end
        if (xfer_fail === 1'b1) begin
            n_fail   <= n_fail + 1;
            fail_cyc <= cyc;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge netclk);
        #1;
    endtask

    function automatic int count_of(input int which);
        case (which)
            0:       return n_start;
            1:       return n_done;
            default: return n_fail;
        endcase
    endfunction

    task automatic wait_count(input string tag, input int which, input int target, input int budget);
        int k = 0;
        while (count_of(which) < target && k < budget) begin
            cycles(1);
            k++;
        end
        check(tag, count_of(which), target);
    endtask

    task automatic request(input logic bcast);
        xfer_bcast = bcast;
        xfer_req   = 1'b1;
        cycles(1);
        xfer_req   = 1'b0;
    endtask

    task automatic pulse_tx_done();
        tx_done = 1'b1;
        cycles(1);
        tx_done = 1'b0;
    endtask

    task automatic rx_frame(input logic valid, input logic abort);
        rx_complete = 1'b1;
        rx_valid    = valid;
        rx_abort    = abort;
        cycles(1);
        rx_complete = 1'b0;
        rx_abort    = 1'b0;
    endtask

    task automatic rx_abort_only();
        rx_abort = 1'b1;
        cycles(1);
        rx_abort = 1'b0;
    endtask

    initial begin
        int r, a, d, s0, l, e;

        // Reset state
        cycles(2);
        check("rst_busy", busy, 1'b0);
        check("rst_tx_start", tx_start, 1'b0);
        check("rst_done", xfer_done, 1'b0);
        check("rst_fail", xfer_fail, 1'b0);
        check("rst_fail_code", fail_code, 2'b00);
        reset = 1'b0;
        line_idle = 1'b1;
        cycles(20);
        check("idle_busy", busy, 1'b0);

        // 1: full handshake on an idle line
        r = cyc;
        request(1'b0);
        check("t1_busy", busy, 1'b1);
        wait_count("t1_scout", 0, 1, 5);
        check("t1_scout_cyc", start_cyc, r + 1);
        check("t1_scout_sel", last_sel, 1'b0);
        cycles(3);
        pulse_tx_done();
        cycles(100);
        a = cyc;
        rx_frame(1'b1, 1'b0);
        wait_count("t1_data", 0, 2, 3);
        check("t1_data_cyc", start_cyc, a);
        check("t1_data_sel", last_sel, 1'b1);
        cycles(3);
        pulse_tx_done();
        cycles(100);
        a = cyc;
        rx_frame(1'b1, 1'b0);
        wait_count("t1_done", 1, 1, 3);
        check("t1_done_cyc", done_cyc, a);
        check("t1_busy_after", busy, 1'b0);
        check("t1_no_fail", n_fail, 0);
        check("t1_fail_code", fail_code, 2'b00);

        // 2: broken idle periods never reach the threshold
        line_idle = 1'b0;
        cycles(1);
        s0 = n_start;
        request(1'b0);
        for (int i = 0; i < 5; i++) begin
            line_idle = 1'b1;
            cycles(9);
            line_idle = 1'b0;
            cycles(1);
        end
        check("t2_no_start", n_start, s0);
        l = cyc;
        line_idle = 1'b1;
        wait_count("t2_scout", 0, s0 + 1, 40);
        check("t2_scout_cyc", start_cyc, l + 16);

        // 3: scouts never acked -> 4 scouts then fail 01
        d = 0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                wait_count("t3_retry", 0, s0 + 1 + i, 2100);
                check("t3_retry_cyc", start_cyc, d + 2049);
                check("t3_retry_sel", last_sel, 1'b0);
            end
            cycles(2);
            d = cyc;
            pulse_tx_done();
        end
        wait_count("t3_fail", 2, 1, 2100);
        check("t3_fail_cyc", fail_cyc, d + 2048);
        check("t3_fail_code", fail_code, 2'b01);
        cycles(30);
        check("t3_scouts", n_start, s0 + 4);
        check("t3_busy", busy, 1'b0);

        // 4: scout acked, data answered by an invalid frame
        s0 = n_start;
        request(1'b0);
        check("t4_code_clr", fail_code, 2'b00);
        wait_count("t4_scout", 0, s0 + 1, 5);
        cycles(2);
        pulse_tx_done();
        cycles(5);
        rx_frame(1'b1, 1'b0);
        wait_count("t4_data", 0, s0 + 2, 3);
        cycles(2);
        pulse_tx_done();
        cycles(5);
        e = cyc;
        rx_frame(1'b0, 1'b0);
        wait_count("t4_fail", 2, 2, 3);
        check("t4_fail_cyc", fail_cyc, e);
        check("t4_fail_code", fail_code, 2'b10);
        cycles(20);
        check("t4_no_redata", n_start, s0 + 2);
        check("t4_busy", busy, 1'b0);
        check("t4_code_held", fail_code, 2'b10);

        // 5: abort and valid frame together in ACK1 -> NAK, one retry used
        s0 = n_start;
        request(1'b0);
        wait_count("t5_scout", 0, s0 + 1, 5);
        cycles(2);
        pulse_tx_done();
        cycles(5);
        e = cyc;
        rx_frame(1'b1, 1'b1);
        wait_count("t5_retry", 0, s0 + 2, 5);
        check("t5_retry_cyc", start_cyc, e + 1);
        check("t5_retry_sel", last_sel, 1'b0);
        check("t5_no_done", n_done, 1);
        cycles(2);
        pulse_tx_done();
        cycles(5);
        rx_abort_only();
        wait_count("t5_retry2", 0, s0 + 3, 5);
        cycles(2);
        pulse_tx_done();
        cycles(5);
        rx_frame(1'b0, 1'b0);
        wait_count("t5_retry3", 0, s0 + 4, 5);
        cycles(2);
        pulse_tx_done();
        cycles(5);
        e = cyc;
        rx_abort_only();
        wait_count("t5_fail", 2, 3, 3);
        check("t5_fail_cyc", fail_cyc, e);
        check("t5_fail_code", fail_code, 2'b01);
        check("t5_scouts", n_start, s0 + 4);

        // 6: reset while waiting for the data ack
        s0 = n_start;
        request(1'b0);
        wait_count("t6_scout", 0, s0 + 1, 5);
        cycles(2);
        pulse_tx_done();
        cycles(3);
        rx_frame(1'b1, 1'b0);
        wait_count("t6_data", 0, s0 + 2, 3);
        cycles(2);
        pulse_tx_done();
        cycles(10);
        reset = 1'b1;
        #1;
        check("t6_busy", busy, 1'b0);
        check("t6_tx_start", tx_start, 1'b0);
        check("t6_done", xfer_done, 1'b0);
        check("t6_fail", xfer_fail, 1'b0);
        check("t6_fail_code", fail_code, 2'b00);
        cycles(2);
        reset = 1'b0;
        cycles(20);
        check("t6_no_done", n_done, 1);
        check("t6_no_fail", n_fail, 3);
        rx_frame(1'b1, 1'b0);
        cycles(3);
        check("t6_idle_ignore", n_start, s0 + 2);
        request(1'b0);
        wait_count("t6_restart", 0, s0 + 3, 30);
        check("t6_restart_sel", last_sel, 1'b0);

        // Broadcast request
        reset = 1'b1;
        cycles(2);
        reset = 1'b0;
        cycles(20);
        s0 = n_start;
        request(1'b1);
        wait_count("bc_scout", 0, s0 + 1, 5);
        check("bc_sel", last_sel, 1'b0);
        cycles(2);
`ifdef ECONET_BCAST_EN
        d = cyc;
        pulse_tx_done();
        wait_count("bc_done", 1, 2, 3);
        check("bc_done_cyc", done_cyc, d);
        check("bc_busy", busy, 1'b0);
        cycles(20);
        check("bc_one_frame", n_start, s0 + 1);
`else
        pulse_tx_done();
        cycles(10);
        check("bc_ignored_busy", busy, 1'b1);
        check("bc_ignored_done", n_done, 1);
        rx_frame(1'b1, 1'b0);
        wait_count("bc_ignored_data", 0, s0 + 2, 3);
        check("bc_ignored_sel", last_sel, 1'b1);
`endif
        xfer_bcast = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
